// File: rtl/vt52_pkg.sv
// Shared definitions for the vt52 board top level.
// Holds the reset sequencer state encoding, the reset-cause codes and a helper
// that sizes counters from their terminal count.
package vt52_pkg;

  // Reset sequencer states.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,  // every domain held in reset
    ST_RELEASE = 2'd1,  // domains dropping out of reset one by one
    ST_RUN     = 2'd2   // every domain running
  } seq_state_e;

  // Last reset cause, as seen on reset_seq.cause. 2'b11 is never produced.
  typedef enum logic [1:0] {
    CAUSE_BTN  = 2'b00,  // reset button or power-up
    CAUSE_SOFT = 2'b01,  // soft-reset request
    CAUSE_WDT  = 2'b10   // watchdog expiry
  } cause_e;

  // Width of a counter that must hold 0 .. limit-1; never narrower than 1 bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rst_wdt.sv
// Watchdog counter for the reset sequencer.
// Counts cycles while the board is running with the watchdog enabled and emits
// a one-cycle expire pulse when WDT_CYCLES such cycles pass without a kick.
//
// Ports:
//   clk50     system clock, rising edge
//   resetbtn  synchronous active-low reset
//   run       high while the sequencer is in RUN
//   wdt_en    watchdog enable level
//   wdt_kick  single-cycle kick, restarts the timeout
//   expire    one-cycle pulse on the edge the timeout is reached
module rst_wdt
  import vt52_pkg::*;
#(
  parameter int WDT_CYCLES = 50000000
) (
  input  logic clk50,
  input  logic resetbtn,
  input  logic run,
  input  logic wdt_en,
  input  logic wdt_kick,
  output logic expire
);

  localparam int WDT_W = cnt_w(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] cnt_q;

  // A kick in the timeout cycle wins, so the kick term masks the pulse.
  assign expire = run && wdt_en && !wdt_kick && (cnt_q == WDT_LAST);

  // The counter is cleared on expiry, so it never passes WDT_LAST and can
  // never wrap.
  always_ff @(posedge clk50) begin
    if (!resetbtn || !run || !wdt_en || wdt_kick || expire) begin
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values, whatever order the blocks run in.
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Board reset sequencer.
// Holds NCH reset domains in reset for POR_CYCLES cycles, then releases them in
// ascending order, STAGGER cycles apart. A soft-reset request or a watchdog
// expiry restarts the sequence; the cause of the last restart is kept in a
// sticky register.
//
// Ports:
//   clk50     system clock, 50 MHz, rising edge
//   resetbtn  synchronous active-low reset, already synchronised upstream
//   sw_req    soft-reset request, single-cycle pulse
//   wdt_en    watchdog enable level
//   wdt_kick  watchdog kick, single-cycle pulse
//   rst_out   per-domain reset, active-high, registered
//   rst_done  high while all domains are released, registered
//   cause     last reset cause (vt52_pkg::cause_e), registered
module reset_seq
  import vt52_pkg::*;
#(
  parameter int NCH        = 3,
  parameter int POR_CYCLES = 64,
  parameter int STAGGER    = 16,
  parameter int WDT_CYCLES = 50000000
) (
  input  logic           clk50,
  input  logic           resetbtn,
  input  logic           sw_req,
  input  logic           wdt_en,
  input  logic           wdt_kick,
  output logic [NCH-1:0] rst_out,
  output logic           rst_done,
  output logic [1:0]     cause
);

  localparam int HOLD_W = cnt_w(POR_CYCLES);
  localparam int STG_W  = cnt_w(STAGGER);
  localparam int IDX_W  = cnt_w(NCH);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NCH - 1);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NCH-1:0]    rst_q, rst_d;
  logic              done_q, done_d;
  cause_e            cause_q, cause_d;
  logic              wdt_expire;

  rst_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk50   (clk50),
    .resetbtn(resetbtn),
    .run     (state_q == ST_RUN),
    .wdt_en  (wdt_en),
    .wdt_kick(wdt_kick),
    .expire  (wdt_expire)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;

    // A soft request outranks a watchdog expiry in the same cycle; the button
    // outranks both and is handled in the register process.
    if (sw_req || wdt_expire) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      stg_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      cause_d = sw_req ? CAUSE_SOFT : CAUSE_WDT;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rst_d[0] = 1'b0;
            if (NCH == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
              stg_d   = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (stg_q == STG_LAST) begin
            // Only the bit at the current index drops; lower bits are already
            // clear, so release order stays monotonic.
            rst_d = rst_q & ~(NCH'(1) << idx_q);
            stg_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end

        ST_RUN: ;

        default: begin
          // Unreachable encoding: fall back to a full restart.
          state_d = ST_HOLD;
          hold_d  = '0;
          stg_d   = '0;
          idx_d   = '0;
          rst_d   = '1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (!resetbtn) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_BTN;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out  = rst_q;
  assign rst_done = done_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Testbench for reset_seq. Three instances (default-like, NCH=1/POR=1 and
// NCH=8/STAGGER=1, all with a 10-cycle watchdog) share one stimulus stream.
// Each is tracked by a model that measures the age of the current reset
// sequence and the run of unkicked watchdog cycles.
module tb_reset_seq;

  typedef struct {
    int         age;    // edges since the last reset event
    int         quiet;  // consecutive enabled, unkicked edges spent in RUN
    logic [1:0] cause;
  } mdl_t;

  logic       clk50;
  logic       resetbtn;
  logic       sw_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic [2:0] rst_a;
  logic [0:0] rst_b;
  logic [7:0] rst_c;
  logic       done_a, done_b, done_c;
  logic [1:0] cause_a, cause_b, cause_c;

  int   n_checks;
  int   n_errors;
  int   cyc;
  int   base;
  bit   valid;
  mdl_t ma, mb, mc;

  reset_seq #(.NCH(3), .POR_CYCLES(64), .STAGGER(16), .WDT_CYCLES(10)) u_a (
    .clk50(clk50), .resetbtn(resetbtn), .sw_req(sw_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .rst_out(rst_a), .rst_done(done_a), .cause(cause_a));

  reset_seq #(.NCH(1), .POR_CYCLES(1), .STAGGER(16), .WDT_CYCLES(10)) u_b (
    .clk50(clk50), .resetbtn(resetbtn), .sw_req(sw_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .rst_out(rst_b), .rst_done(done_b), .cause(cause_b));

  reset_seq #(.NCH(8), .POR_CYCLES(64), .STAGGER(1), .WDT_CYCLES(10)) u_c (
    .clk50(clk50), .resetbtn(resetbtn), .sw_req(sw_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .rst_out(rst_c), .rst_done(done_c), .cause(cause_c));

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp,
               cyc - base);
    end
  endtask

  // One edge of the specification's rules.
  function automatic mdl_t step(input mdl_t m, input int last_fall,
                                input int wdt, input logic btn,
                                input logic sw, input logic en,
                                input logic kick);
    mdl_t n;
    bit   running;
    n       = m;
    running = (m.age >= last_fall);
    if (!btn) begin
      n.age = 0; n.quiet = 0; n.cause = 2'b00;
    end else if (sw) begin
      n.age = 0; n.quiet = 0; n.cause = 2'b01;
    end else begin
      n.quiet = (running && en && !kick) ? m.quiet + 1 : 0;
      if (n.quiet == wdt) begin
        n.age = 0; n.quiet = 0; n.cause = 2'b10;
      end else if (n.age < 1000000) begin
        n.age = m.age + 1;
      end
    end
    return n;
  endfunction

  // Bit i is held while the sequence is younger than its release edge.
  function automatic logic [31:0] exp_rst(input mdl_t m, input int nch,
                                          input int por, input int stg);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nch; i++) r[i] = (m.age < por + i * stg);
    return r;
  endfunction

  always @(posedge clk50) begin
    cyc++;
    ma = step(ma, 64 + 2 * 16, 10, resetbtn, sw_req, wdt_en, wdt_kick);
    mb = step(mb, 1, 10, resetbtn, sw_req, wdt_en, wdt_kick);
    mc = step(mc, 64 + 7 * 1, 10, resetbtn, sw_req, wdt_en, wdt_kick);
    if (!resetbtn) valid = 1'b1;
    if (cyc > 20000) begin
      $display("FAIL timeout: got %0d edges, expected at most 20000", cyc);
      $fatal(1, "bench ran out of cycles");
    end
  end

  // Cycle-by-cycle comparison against the models.
  always @(negedge clk50) begin
    if (valid) begin
      check("a_rst_out", 32'(rst_a), exp_rst(ma, 3, 64, 16));
      check("a_done", 32'(done_a), 32'(ma.age >= 96));
      check("a_cause", 32'(cause_a), 32'(ma.cause));
      check("b_rst_out", 32'(rst_b), exp_rst(mb, 1, 1, 16));
      check("b_done", 32'(done_b), 32'(mb.age >= 1));
      check("b_cause", 32'(cause_b), 32'(mb.cause));
      check("c_rst_out", 32'(rst_c), exp_rst(mc, 8, 64, 1));
      check("c_done", 32'(done_c), 32'(mc.age >= 71));
      check("c_cause", 32'(cause_c), 32'(mc.cause));
    end
  end

  task automatic at_edge(input int n);
    while (cyc < base + n) @(negedge clk50);
  endtask

  task automatic restart();
    @(negedge clk50);
    resetbtn = 1'b0;
    @(negedge clk50);
    resetbtn = 1'b1;
    base = cyc;
  endtask

  task automatic pulse_sw(input int k);
    at_edge(k - 1);
    sw_req = 1'b1;
    at_edge(k);
    sw_req = 1'b0;
  endtask

  task automatic pulse_kick(input int k);
    at_edge(k - 1);
    wdt_kick = 1'b1;
    at_edge(k);
    wdt_kick = 1'b0;
  endtask

  int kk;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; base = 0; valid = 1'b0;
    ma = '{age: 0, quiet: 0, cause: 2'b00};
    mb = ma;
    mc = ma;
    resetbtn = 1'b0; sw_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;

    repeat (3) @(negedge clk50);
    check("reset_rst_out", 32'(rst_a), 32'h7);
    check("reset_done", 32'(done_a), 32'h0);
    check("reset_cause", 32'(cause_a), 32'h0);

    // Power-up sequence.
    restart();
    at_edge(1);
    check("b_por1_rst_out", 32'(rst_b), 32'h0);
    check("b_por1_done", 32'(done_b), 32'h1);
    at_edge(63);  check("pu_63", 32'(rst_a), 32'h7);
    at_edge(64);  check("pu_64", 32'(rst_a), 32'h6);
                  check("c_64", 32'(rst_c), 32'hFE);
    at_edge(70);  check("c_70", 32'(rst_c), 32'h80);
    at_edge(71);  check("c_71", 32'(rst_c), 32'h00);
                  check("c_71_done", 32'(done_c), 32'h1);
    at_edge(80);  check("pu_80", 32'(rst_a), 32'h4);
    at_edge(95);  check("pu_95_done", 32'(done_a), 32'h0);
    at_edge(96);  check("pu_96", 32'(rst_a), 32'h0);
                  check("pu_96_done", 32'(done_a), 32'h1);
                  check("pu_96_cause", 32'(cause_a), 32'h0);

    // One-cycle button press mid-release.
    restart();
    at_edge(84);
    resetbtn = 1'b0;
    at_edge(85);
    resetbtn = 1'b1;
    check("btn_85", 32'(rst_a), 32'h7);
    check("btn_85_done", 32'(done_a), 32'h0);
    at_edge(148); check("btn_148", 32'(rst_a), 32'h7);
    at_edge(149); check("btn_149", 32'(rst_a), 32'h6);
    at_edge(181); check("btn_181", 32'(rst_a), 32'h0);
                  check("btn_181_done", 32'(done_a), 32'h1);

    // Soft resets.
    restart();
    pulse_sw(200);
    check("sw_200", 32'(rst_a), 32'h7);
    check("sw_200_done", 32'(done_a), 32'h0);
    check("sw_200_cause", 32'(cause_a), 32'h1);
    at_edge(263); check("sw_263", 32'(rst_a), 32'h7);
    at_edge(264); check("sw_264", 32'(rst_a), 32'h6);
    pulse_sw(270);
    check("sw_270", 32'(rst_a), 32'h7);
    at_edge(296); check("sw_296", 32'(rst_a), 32'h7);
                  check("sw_296_done", 32'(done_a), 32'h0);
    at_edge(365); check("sw_365", 32'(rst_a), 32'h4);
    at_edge(366); check("sw_366_done", 32'(done_a), 32'h1);
                  check("sw_366_cause", 32'(cause_a), 32'h1);

    // Watchdog timeout, then regular kicks.
    wdt_en = 1'b1;
    at_edge(375); check("wdt_375_done", 32'(done_a), 32'h1);
    at_edge(376); check("wdt_376", 32'(rst_a), 32'h7);
                  check("wdt_376_done", 32'(done_a), 32'h0);
                  check("wdt_376_cause", 32'(cause_a), 32'h2);
    for (int j = 0; j < 112; j++) pulse_kick(380 + 9 * j);
    kk = 380 + 9 * 111;
    check("kick_done", 32'(done_a), 32'h1);
    check("kick_cause", 32'(cause_a), 32'h2);

    // Soft request in the timeout cycle.
    at_edge(kk + 9); check("col_pre_done", 32'(done_a), 32'h1);
    pulse_sw(kk + 10);
    check("col_sw_cause", 32'(cause_a), 32'h1);
    check("col_sw_rst", 32'(rst_a), 32'h7);

    // Kick in the timeout cycle.
    pulse_kick(kk + 10 + 96 + 10);
    check("col_kick_done", 32'(done_a), 32'h1);
    at_edge(kk + 10 + 96 + 11);
    check("col_kick_done2", 32'(done_a), 32'h1);

    // Button together with a soft request in the next timeout cycle.
    at_edge(kk + 10 + 96 + 19);
    resetbtn = 1'b0;
    sw_req   = 1'b1;
    at_edge(kk + 10 + 96 + 20);
    resetbtn = 1'b1;
    sw_req   = 1'b0;
    check("col_btn_cause", 32'(cause_a), 32'h0);
    check("col_btn_rst", 32'(rst_a), 32'h7);
    check("col_btn_done", 32'(done_a), 32'h0);

    repeat (5) @(negedge clk50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
